// File: rtl/ps2_kb_pkg.sv
// ps2_kb_pkg: frame states, set-2 scan codes and HID usage codes for the PS/2 keyboard front end.
package ps2_kb_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] HID_A     = 8'h04;
  localparam logic [7:0] HID_D     = 8'h07;
  localparam logic [7:0] HID_SPACE = 8'h2C;
  localparam logic [7:0] HID_NONE  = 8'h00;
  // Fixed priority A > D > Space when several keys are held.
  function automatic logic [7:0] hid_of(input logic [2:0] m);
    return m[0] ? HID_A : m[1] ? HID_D : m[2] ? HID_SPACE : HID_NONE;
  endfunction
  function automatic logic [2:0] mask_of(input logic [7:0] h);
    return h == HID_A ? 3'b001 : h == HID_D ? 3'b010 : h == HID_SPACE ? 3'b100 : 3'b000;
  endfunction
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises PS/2 clock/data, deframes 11-bit frames and checks odd parity and stop bit.
// Defining PS2_TIMEOUT_EN adds a watchdog that abandons a stalled partial frame.
module ps2_frame_rx
  import ps2_kb_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] data_byte,
  output logic       frame_err
);
  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic clk_s, data_s, clk_prev, fall, frame_ok, timeout, par;
  logic [2:0] bit_cnt;
  frame_state_t state, state_n;
  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign data_s   = data_sync[SYNC_STAGES-1];
  assign fall     = clk_prev & ~clk_s;
  assign frame_ok = (^{data_byte, par}) & data_s;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (timeout) state_n = IDLE;
    else if (fall)
      case (state)
        IDLE:    state_n = data_s ? IDLE : DATA;
        DATA:    state_n = bit_cnt == 3'd7 ? PARITY : DATA;
        PARITY:  state_n = STOP;
        default: state_n = IDLE;
      endcase
  end
  // Synchronisers reset to the idle-high line level so release never fakes an edge.
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      clk_sync   <= '1;
      data_sync  <= '1;
      clk_prev   <= 1'b1;
      bit_cnt    <= 3'd0;
      data_byte  <= 8'h00;
      par        <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync  <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev   <= clk_s;
      byte_valid <= fall && state == STOP && frame_ok;
      frame_err  <= fall && state == STOP && !frame_ok;
      if (timeout) bit_cnt <= 3'd0;
      else if (fall && state == DATA) begin
        data_byte <= {data_s, data_byte[7:1]};
        bit_cnt   <= bit_cnt + 3'd1;
      end
      if (fall && state == PARITY) par <= data_s;
    end
`ifdef PS2_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  logic [WW-1:0] wdog;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) wdog <= '0;
    else wdog <= (state == IDLE || fall) ? '0 : wdog + 1'b1;
  assign timeout = state != IDLE && !fall && wdog == WW'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif
endmodule

// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx: PS/2 set-2 keyboard to held HID keycode (A, D, Space, arrows), tracking E0/F0 prefixes.
// Optional frame watchdog enabled by defining PS2_TIMEOUT_EN.
module ps2_keycode_rx
  import ps2_kb_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic [2:0] key_mask,
  output logic       frame_err
);
  logic       byte_valid, brk, ext, is_brk, is_ext;
  logic [7:0] code, keycode_n;
  logic [2:0] hit, mask_n, made;
  ps2_frame_rx #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_frame (
    .Clk(Clk), .Reset(Reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .byte_valid(byte_valid), .data_byte(code), .frame_err(frame_err)
  );
  assign is_brk = code == SC_BREAK;
  assign is_ext = code == SC_EXT;
  assign hit = {~ext & (code == SC_SPACE),
                (~ext & (code == SC_D)) | (ext & (code == SC_RIGHT)),
                (~ext & (code == SC_A)) | (ext & (code == SC_LEFT))};
  assign mask_n = (byte_valid && !is_brk && !is_ext) ? (brk ? key_mask & ~hit : key_mask | hit) : key_mask;
  assign made = mask_n & ~key_mask;
  // A fresh make wins; losing the active key falls back by priority; anything else holds.
  assign keycode_n = |made ? hid_of(made) : |(mask_of(keycode) & ~mask_n) ? hid_of(mask_n) : keycode;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      brk      <= 1'b0;
      ext      <= 1'b0;
      key_mask <= 3'b000;
      keycode  <= HID_NONE;
    end else begin
      if (byte_valid) begin
        brk <= is_brk | (is_ext & brk);
        ext <= is_ext | (is_brk & ext);
      end
      key_mask <= mask_n;
      keycode  <= keycode_n;
    end
endmodule

// File: tb/tb_ps2_keycode_rx.sv
// tb_ps2_keycode_rx: directed PS/2 frames with hand-computed keycode/key_mask/frame_err expectations.
module tb_ps2_keycode_rx;
  logic       Clk = 1'b0, Reset = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] keycode;
  logic [2:0] key_mask;
  logic       frame_err;
  int checks = 0, errors = 0, err_pulses = 0;

  ps2_keycode_rx dut (
    .Clk(Clk), .Reset(Reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keycode(keycode), .key_mask(key_mask), .frame_err(frame_err)
  );

  always #10 Clk = ~Clk;
  always @(posedge Clk) if (frame_err) err_pulses++;

  task automatic wait_neg(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Leaves ps2_clk low right at the falling edge of this bit.
  task automatic ps2_bit(input logic b);
    wait_neg(4);
    ps2_clk = 1'b1;
    ps2_data = b;
    wait_neg(4);
    ps2_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b ^ bad_par);
    ps2_bit(stop);
  endtask

  task automatic idle();
    wait_neg(5);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_neg(5);
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_byte(b, 1'b0, 1'b1);
    idle();
  endtask

  task automatic expect_out(input string name, input logic [7:0] kc, input logic [2:0] km);
    checks++;
    if ({keycode, key_mask} !== {kc, km}) begin
      errors++;
      $display("FAIL %s keycode=%h key_mask=%b expected keycode=%h key_mask=%b", name, keycode, key_mask, kc, km);
    end
  endtask

  task automatic test_reset();
    wait_neg(3);
    checks++;
    if ({keycode, key_mask, frame_err} !== 12'h000) begin
      errors++;
      $display("FAIL reset keycode=%h key_mask=%b frame_err=%b expected 00/000/0", keycode, key_mask, frame_err);
    end
    Reset = 1'b1;
    wait_neg(5);
  endtask

  task automatic test_make_break();
    send_byte(8'h1C, 1'b0, 1'b1);
    wait_neg(3);
    expect_out("latency_before", 8'h00, 3'b000);
    wait_neg(1);
    expect_out("make_a", 8'h04, 3'b001);
    idle();
    send_frame(8'hF0);
    send_frame(8'h1C);
    expect_out("break_a", 8'h00, 3'b000);
  endtask

  task automatic test_priority();
    send_frame(8'h23);
    expect_out("make_d", 8'h07, 3'b010);
    send_frame(8'h1C);
    expect_out("make_a_over_d", 8'h04, 3'b011);
    send_frame(8'h1C);
    expect_out("typematic_a", 8'h04, 3'b011);
    send_frame(8'hF0); send_frame(8'h1C);
    expect_out("break_active_a", 8'h07, 3'b010);
    send_frame(8'h1C);
    send_frame(8'hF0); send_frame(8'h23);
    expect_out("break_inactive_d", 8'h04, 3'b001);
    send_frame(8'h29);
    send_frame(8'h23);
    expect_out("make_d_last", 8'h07, 3'b111);
    send_frame(8'hF0); send_frame(8'h23);
    expect_out("fallback_a", 8'h04, 3'b101);
    send_frame(8'hF0); send_frame(8'h1C);
    expect_out("fallback_space", 8'h2C, 3'b100);
    send_frame(8'hF0); send_frame(8'h29);
    expect_out("all_released", 8'h00, 3'b000);
  endtask

  task automatic test_frame_err();
    int p0;
    p0 = err_pulses;
    send_byte(8'h1C, 1'b1, 1'b1);
    idle();
    checks++;
    if (err_pulses - p0 !== 1) begin
      errors++;
      $display("FAIL parity_err_pulse cycles=%0d expected 1", err_pulses - p0);
    end
    expect_out("parity_discard", 8'h00, 3'b000);
    send_byte(8'h23, 1'b0, 1'b0);
    idle();
    checks++;
    if (err_pulses - p0 !== 2) begin
      errors++;
      $display("FAIL stop_err_pulse cycles=%0d expected 2", err_pulses - p0);
    end
    expect_out("stop_discard", 8'h00, 3'b000);
    send_frame(8'h29);
    expect_out("after_err_space", 8'h2C, 3'b100);
    send_frame(8'hF0); send_frame(8'h29);
    checks++;
    if (err_pulses - p0 !== 2) begin
      errors++;
      $display("FAIL spurious_err cycles=%0d expected 2", err_pulses - p0);
    end
  endtask

  task automatic test_extended();
    send_frame(8'hE0); send_frame(8'h6B);
    expect_out("ext_left", 8'h04, 3'b001);
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h6B);
    expect_out("ext_left_break", 8'h00, 3'b000);
    send_frame(8'h6B);
    expect_out("plain_6b", 8'h00, 3'b000);
    send_frame(8'hE0); send_frame(8'h74);
    expect_out("ext_right", 8'h07, 3'b010);
    send_frame(8'hE0); send_frame(8'h1C);
    expect_out("ext_1c_ignored", 8'h07, 3'b010);
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h74);
    expect_out("ext_right_break", 8'h00, 3'b000);
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'h29);
    expect_out("pre_reset_space", 8'h2C, 3'b100);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    Reset = 1'b0;
    #1;
    expect_out("async_reset", 8'h00, 3'b000);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_neg(5);
    Reset = 1'b1;
    wait_neg(5);
    send_frame(8'h29);
    expect_out("post_reset_space", 8'h2C, 3'b100);
    send_frame(8'hF0); send_frame(8'h29);
  endtask

`ifdef PS2_TIMEOUT_EN
  task automatic test_timeout();
    int p0;
    p0 = err_pulses;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    idle();
    wait_neg(50010);
    checks++;
    if (err_pulses - p0 !== 0) begin
      errors++;
      $display("FAIL timeout_err cycles=%0d expected 0", err_pulses - p0);
    end
    send_frame(8'h23);
    expect_out("after_timeout_d", 8'h07, 3'b010);
    send_frame(8'hF0); send_frame(8'h23);
  endtask
`endif

  initial begin
    test_reset();
    test_make_break();
    test_priority();
    test_frame_err();
    test_extended();
    test_reset_mid_frame();
`ifdef PS2_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_keycode_rx.md
Name: ps2_keycode_rx

Overview:
- PS/2 keyboard front end. Receives set-2 scan-code frames from the keyboard and produces the level-held 8-bit `keycode` bus that the player and shot logic consume.
- Output uses HID usage values: A=8'h04, D=8'h07, Space=8'h2C, none=8'h00.
- Tracks make/break (F0) and extended (E0) prefixes, so `keycode` stays asserted for as long as the key is physically held.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the synchronisers on `ps2_clk` and `ps2_data`.
- TIMEOUT_CYCLES, 50000, `Clk` cycles without a PS/2 falling edge before a partial frame is abandoned (1 ms at 50 MHz).

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock from the keyboard, asynchronous.
- ps2_data  in  1  raw PS/2 data from the keyboard, asynchronous.
- keycode  out  8  HID code of the active held key; 8'h00 when no supported key is held.
- key_mask  out  3  held flags: bit0 = A, bit1 = D, bit2 = Space.
- frame_err  out  1  one-cycle pulse on a parity or stop-bit error.

Behaviour:
- Reset (Reset=0, async) clears everything: `keycode`=8'h00, `key_mask`=3'b000, `frame_err`=0, FSM=IDLE, prefix flags cleared, bit counter=0, watchdog=0.
- Reset mid-frame discards the partial byte.
- Input conditioning: `ps2_clk` and `ps2_data` each pass through SYNC_STAGES flops. A falling edge is one `Clk` cycle where the previous synced clock is 1 and the current one is 0. All sampling happens on these edge cycles only.
- Frame FSM:
  - IDLE -> DATA when the sampled start bit is 0; a 1 leaves the FSM in IDLE.
  - DATA: shift 8 bits LSB first, 3-bit counter 0..7, then -> PARITY.
  - PARITY: latch the parity bit, -> STOP.
  - STOP: check odd parity (XOR of 8 data bits and parity bit must be 1) and stop bit = 1.
    - Both good: raise internal `byte_valid` the following cycle, -> IDLE.
    - Either bad: pulse `frame_err` the following cycle, discard the byte, -> IDLE.
- Decode layer, acts on `byte_valid`:
  - 8'hF0 sets `brk`. 8'hE0 sets `ext`. Both may be set together (E0 F0 xx).
  - Any other byte is looked up as {ext, code}:
    - {0,1C} -> A; {0,23} -> D; {0,29} -> Space.
    - {1,6B} (left arrow) -> A; {1,74} (right arrow) -> D.
  - A matched byte sets its `key_mask` bit when brk=0 and clears it when brk=1.
  - Unmatched bytes change nothing.
  - Any non-prefix byte clears both `brk` and `ext`.
- Output select:
  - A new make (bit 0->1) makes that key the active key.
  - On break of the active key, the active key falls back to the first remaining held key in fixed priority A > D > Space; if none remain, `keycode` = 8'h00.
  - Break of a non-active key leaves `keycode` unchanged.
  - A repeated make of a held key (typematic) changes nothing.
- Latency: stop bit sampled at edge cycle N -> `byte_valid`/`frame_err` at N+1 -> `key_mask` and `keycode` registered at N+2.
- Simultaneous events: reset dominates everything. Only one byte can complete per frame, so no decode conflicts arise.

Optional Feature:
- PS2_TIMEOUT_EN defined:
  - The watchdog counts `Clk` cycles while the FSM is not IDLE and clears on every falling edge.
  - Reaching TIMEOUT_CYCLES-1 forces IDLE and clears the bit counter.
  - `frame_err` is not pulsed; `key_mask` and the prefix flags are kept.
- Not defined: no watchdog is built. A stalled frame holds the FSM in place until the next edges arrive or Reset.

Decomposition:
- Package `ps2_kb_pkg` holds:
  - the frame state enum (IDLE, DATA, PARITY, STOP);
  - scan-code constants SC_A, SC_D, SC_SPACE, SC_LEFT, SC_RIGHT, SC_BREAK, SC_EXT;
  - HID constants HID_A, HID_D, HID_SPACE, HID_NONE.
- Sub-module `ps2_frame_rx` contains the synchronisers, edge detector, FSM, parity check and watchdog, and outputs `byte_valid`, `byte`, `frame_err`.
- The top module contains the prefix tracking, `key_mask` and active-key select.

Test Plan:
- Frame 1C -> `keycode`=8'h04, `key_mask`=3'b001 two cycles after the stop edge; then F0,1C -> `keycode`=8'h00, `key_mask`=3'b000.
- Make D (23), then make A (1C) -> `keycode` goes 8'h07 then 8'h04; break A -> `keycode`=8'h07, `key_mask`=3'b010.
- Frame 1C sent with even parity -> one-cycle `frame_err`=1; `keycode` and `key_mask` stay 0; the next valid 29 gives `keycode`=8'h2C.
- E0,6B -> `keycode`=8'h04; E0,F0,6B -> 8'h00; plain 6B (no E0) -> unchanged at 8'h00.
- With PS2_TIMEOUT_EN: 5 bits sent, stall 50000 cycles -> FSM back in IDLE, no `frame_err`; the next full 23 frame gives `keycode`=8'h07.
- Reset pulled low after 4 data bits of a frame -> `keycode`=8'h00 immediately; after release, frame 29 decodes to 8'h2C.
